// File: rtl/mac_pat_chk_pkg.sv
// Shared constants, state encoding and helpers for the MAC test-frame checker.
package mac_pat_pkg;

    localparam int unsigned HDR_LEN = 14;
    localparam int unsigned IDX_W   = 17;
    localparam int unsigned ERR_W   = 5;

    localparam int unsigned ERR_DST     = 0;
    localparam int unsigned ERR_SRC     = 1;
    localparam int unsigned ERR_LEN_FLD = 2;
    localparam int unsigned ERR_DATA    = 3;
    localparam int unsigned ERR_FRM_LEN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR,
        ST_PAY,
        ST_DRAIN
    } state_t;

    // Byte 'pos' of a MAC address in wire order ([47:40] is byte 0)
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] pos);
        logic [47:0] sh;
        sh = mac << {pos, 3'b000};
        return sh[47:40];
    endfunction

endpackage

// File: rtl/mac_pat_chk_if.sv
// RX byte stream from the MAC receive path (no backpressure).
interface mac_pat_chk_if;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rlast;

    modport master (output rdata, output rvalid, output rlast);
    modport slave  (input  rdata, input  rvalid, input  rlast);
endinterface

// File: rtl/mac_pat_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module mac_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    // Count up, hold at all-ones
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/mac_pat_chk.sv
// mac_pat_chk: receive-side checker for MAC test frames.
// Frame: dst(6) | src(6) | length(2, MSB first) | payload byte k = k[7:0].
module mac_pat_chk
    import mac_pat_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter bit          CHK_SRC = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             chk_en,
    input  logic             chk_clr,
    input  logic [47:0]      exp_dst_mac,
    input  logic [47:0]      exp_src_mac,
    input  logic [15:0]      exp_dlen,
    mac_pat_chk_if.slave     rx,
    output logic             frm_done,
    output logic             frm_ok,
    output logic [CNT_W-1:0] frm_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ERR_W-1:0] err_code,
    output logic [31:0]      rx_bytes
);
    localparam logic [IDX_W-1:0] IDX_SRC0    = IDX_W'(6);
    localparam logic [IDX_W-1:0] IDX_LEN_HI  = IDX_W'(12);
    localparam logic [IDX_W-1:0] IDX_HDR_END = IDX_W'(HDR_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_PAY0    = IDX_W'(HDR_LEN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_en_s1, r_en_s2, r_en_s3;
    logic [47:0]        r_exp_dst, r_exp_src, r_snap_dst, r_snap_src;
    logic [15:0]        r_exp_dlen, r_snap_dlen;
    logic               r_in_frame;
    logic [IDX_W-1:0]   r_idx;
    logic [ERR_W-1:0]   r_err;
    logic               r_frm_done, r_frm_ok;
    logic [ERR_W-1:0]   r_err_code;
    logic [31:0]        r_rx_bytes;

    logic               w_en_rise;
    logic               w_chk_st;
    logic               w_cnt_st;
    logic               w_first;
    logic [47:0]        w_dst, w_src;
    logic [15:0]        w_dlen;
    logic [IDX_W-1:0]   w_last_idx;
    logic [2:0]         w_src_pos;
    logic [7:0]         w_pay_exp;
    logic [ERR_W-1:0]   w_err_byte;
    logic [ERR_W-1:0]   w_frm_err;
    logic               w_verdict;
    logic               w_inc_ok, w_inc_err;

    assign w_en_rise  = r_en_s2 & ~r_en_s3;
    assign w_chk_st   = (r_state == ST_HDR) || (r_state == ST_PAY);
    assign w_cnt_st   = w_chk_st || (r_state == ST_DRAIN);
    assign w_first    = (r_idx == '0);
    // Byte 0 compares against the live registered value, which is what the snapshot captures
    assign w_dst      = w_first ? r_exp_dst  : r_snap_dst;
    assign w_src      = w_first ? r_exp_src  : r_snap_src;
    assign w_dlen     = w_first ? r_exp_dlen : r_snap_dlen;
    assign w_last_idx = IDX_HDR_END + IDX_W'(w_dlen);
    assign w_frm_err  = r_err | w_err_byte;
    assign w_inc_ok   = w_verdict && (w_frm_err == '0);
    assign w_inc_err  = w_verdict && (w_frm_err != '0);

    // Enable synchroniser plus edge register; expected values registered every cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_en_s1    <= 1'b0;
            r_en_s2    <= 1'b0;
            r_en_s3    <= 1'b0;
            r_exp_dst  <= '0;
            r_exp_src  <= '0;
            r_exp_dlen <= '0;
        end else begin
            r_en_s1    <= chk_en;
            r_en_s2    <= r_en_s1;
            r_en_s3    <= r_en_s2;
            r_exp_dst  <= exp_dst_mac;
            r_exp_src  <= exp_src_mac;
            r_exp_dlen <= exp_dlen;
        end
    end

    // Frame-boundary tracking independent of checker state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_in_frame <= 1'b0;
        end else if (rx.rvalid) begin
            r_in_frame <= ~rx.rlast;
        end
    end

    // Per-frame snapshot of the expected values, taken on byte 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_snap_dst  <= '0;
            r_snap_src  <= '0;
            r_snap_dlen <= '0;
        end else if (w_chk_st && rx.rvalid && w_first) begin
            r_snap_dst  <= r_exp_dst;
            r_snap_src  <= r_exp_src;
            r_snap_dlen <= r_exp_dlen;
        end
    end

    // Per-byte field comparison selected by byte index
    always_comb begin
        w_err_byte = '0;
        w_src_pos  = 3'(r_idx - IDX_SRC0);
        w_pay_exp  = 8'(r_idx - IDX_PAY0);
        if (w_chk_st && rx.rvalid) begin
            if (r_idx < IDX_SRC0) begin
                if (rx.rdata != mac_byte(w_dst, r_idx[2:0])) w_err_byte[ERR_DST] = 1'b1;
            end else if (r_idx < IDX_LEN_HI) begin
                if (CHK_SRC && (rx.rdata != mac_byte(w_src, w_src_pos))) w_err_byte[ERR_SRC] = 1'b1;
            end else if (r_idx == IDX_LEN_HI) begin
                if (rx.rdata != w_dlen[15:8]) w_err_byte[ERR_LEN_FLD] = 1'b1;
            end else if (r_idx == IDX_HDR_END) begin
                if (rx.rdata != w_dlen[7:0]) w_err_byte[ERR_LEN_FLD] = 1'b1;
            end else if (rx.rdata != w_pay_exp) begin
                w_err_byte[ERR_DATA] = 1'b1;
            end
            if (rx.rlast ? (r_idx < w_last_idx) : (r_idx == w_last_idx)) begin
                w_err_byte[ERR_FRM_LEN] = 1'b1;
            end
        end
    end

    // Next-state and verdict decode
    always_comb begin
        w_state_nxt = r_state;
        w_verdict   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_en_rise) w_state_nxt = r_in_frame ? ST_SYNC : ST_HDR;
            end
            ST_SYNC: begin
                if (rx.rvalid && rx.rlast) w_state_nxt = ST_HDR;
            end
            ST_HDR, ST_PAY: begin
                if (rx.rvalid) begin
                    if (rx.rlast) begin
                        w_verdict   = 1'b1;
                        w_state_nxt = r_en_s2 ? ST_HDR : ST_IDLE;
                    end else if (r_idx == w_last_idx) begin
                        w_state_nxt = ST_DRAIN;
                    end else if (r_idx == IDX_HDR_END) begin
                        w_state_nxt = ST_PAY;
                    end
                end
            end
            ST_DRAIN: begin
                if (rx.rvalid && rx.rlast) begin
                    w_verdict   = 1'b1;
                    w_state_nxt = r_en_s2 ? ST_HDR : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Byte index and accumulated error bits of the frame in progress
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx <= '0;
            r_err <= '0;
        end else if (!w_cnt_st) begin
            r_idx <= '0;
            r_err <= '0;
        end else if (rx.rvalid) begin
            if (rx.rlast) begin
                r_idx <= '0;
                r_err <= '0;
            end else begin
                if (w_chk_st) r_idx <= r_idx + IDX_W'(1);
                r_err <= w_frm_err;
            end
        end
    end

    // Verdict, error class and byte count registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frm_done <= 1'b0;
            r_frm_ok   <= 1'b0;
            r_err_code <= '0;
            r_rx_bytes <= '0;
        end else begin
            r_frm_done <= w_verdict;
            r_frm_ok   <= w_inc_ok;
            if (chk_clr)        r_err_code <= '0;
            else if (w_inc_err) r_err_code <= w_frm_err;
            if (chk_clr)                    r_rx_bytes <= '0;
            else if (w_cnt_st && rx.rvalid) r_rx_bytes <= r_rx_bytes + 32'd1;
        end
    end

    mac_sat_cnt #(.W(CNT_W)) u_frm_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .i_clr (chk_clr),
        .i_inc (w_inc_ok),
        .o_cnt (frm_cnt)
    );

    mac_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .i_clr (chk_clr),
        .i_inc (w_inc_err),
        .o_cnt (err_cnt)
    );

    assign frm_done = r_frm_done;
    assign frm_ok   = r_frm_ok;
    assign err_code = r_err_code;
    assign rx_bytes = r_rx_bytes;
endmodule
